// File: rtl/alpha_mem_arb_pkg.sv
// alpha_mem_arb_pkg: packet layout, request types/sizes and source tags shared by the arbiter
package alpha_mem_arb_pkg;
  typedef enum logic [1:0] {PKT_TYPE_FETCH = 2'd0, PKT_TYPE_LOAD = 2'd1, PKT_TYPE_STORE = 2'd2} pkt_type_e;
  typedef enum logic [2:0] {REQ_SZ_BYTE = 3'd0, REQ_SZ_HALF = 3'd1, REQ_SZ_WORD = 3'd2, REQ_SZ_DWORD = 3'd3, REQ_SZ_LINE = 3'd4} pkt_size_e;
  typedef struct packed {
    logic vld;
    logic last;
    pkt_size_e size;
    pkt_type_e typ;
    logic [31:0] addr;
    logic [63:0] data;
  } pkt_t;
  typedef struct packed {
    logic src;
    logic is_line;
  } src_ent_t;
  localparam int PKT_BITS = $bits(pkt_t);
  localparam logic MEM_SRC_I = 1'b0;
  localparam logic MEM_SRC_D = 1'b1;
endpackage

// File: rtl/alpha_mem_arb_if.sv
// alpha_mem_arb_if: client request/response ports and MIU packet bus of the arbiter
interface alpha_mem_arb_if;
  import alpha_mem_arb_pkg::*;
  logic i_req_vld;
  logic [31:0] i_req_addr;
  logic i_req_ack;
  logic i_resp_vld;
  logic [127:0] i_resp_data;
  logic d_req_vld;
  logic [31:0] d_req_addr;
  pkt_type_e d_req_type;
  pkt_size_e d_req_size;
  logic [63:0] d_req_wdata;
  logic d_req_ack;
  logic d_resp_vld;
  logic [127:0] d_resp_data;
  pkt_t cpu_req_pkt_xx;
  logic cpu_req_ack_xx;
  pkt_t cpu_resp_pkt_xx;
  logic err_orphan;
  modport slave (
    input i_req_vld, i_req_addr, d_req_vld, d_req_addr, d_req_type, d_req_size, d_req_wdata,
    input cpu_req_ack_xx, cpu_resp_pkt_xx,
    output i_req_ack, i_resp_vld, i_resp_data, d_req_ack, d_resp_vld, d_resp_data,
    output cpu_req_pkt_xx, err_orphan
  );
  modport master (
    output i_req_vld, i_req_addr, d_req_vld, d_req_addr, d_req_type, d_req_size, d_req_wdata,
    output cpu_req_ack_xx, cpu_resp_pkt_xx,
    input i_req_ack, i_resp_vld, i_resp_data, d_req_ack, d_resp_vld, d_resp_data,
    input cpu_req_pkt_xx, err_orphan
  );
endinterface

// File: rtl/alpha_src_fifo.sv
// alpha_src_fifo: in-order {src, is_line} tracker for outstanding MIU transactions
module alpha_src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] wdata,
  output logic [1:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0] mem_q [DEPTH];
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/alpha_mem_arb.sv
// alpha_mem_arb: round-robin I/D request arbiter into one MIU slot with in-order response routing
module alpha_mem_arb
  import alpha_mem_arb_pkg::*;
#(
  parameter int SRC_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  alpha_mem_arb_if.slave bus
);
  pkt_t slot_q, slot_d, d_pkt, i_pkt;
  logic pref_i_q, pref_i_d, err_q, err_d, i_rv_q, i_rv_d, d_rv_q, d_rv_d;
  logic [63:0] low_q, low_d;
  logic [127:0] i_rd_q, i_rd_d, d_rd_q, d_rd_d, resp_data;
  logic full, empty, fin, can, gnt_i, gnt_d;
  src_ent_t head, push_ent;
  alpha_src_fifo #(.DEPTH(SRC_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(gnt_i | gnt_d), .pop(fin),
    .wdata(push_ent), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    fin = bus.cpu_resp_pkt_xx.vld && !empty && (!head.is_line || bus.cpu_resp_pkt_xx.last);
    // reset gating keeps the combinational acks at 0 while reset is held
    can = reset && (!slot_q.vld || bus.cpu_req_ack_xx) && (!full || fin);
    gnt_d = can && bus.d_req_vld && (!pref_i_q || !bus.i_req_vld);
    gnt_i = can && bus.i_req_vld && !gnt_d;
    pref_i_d = gnt_d ? 1'b1 : gnt_i ? 1'b0 : pref_i_q;
    push_ent.src = gnt_d ? MEM_SRC_D : MEM_SRC_I;
    push_ent.is_line = gnt_i || bus.d_req_size == REQ_SZ_LINE;
    d_pkt = '{vld: 1'b1, last: 1'b0, size: bus.d_req_size, typ: bus.d_req_type, addr: bus.d_req_addr, data: bus.d_req_wdata};
    i_pkt = '{vld: 1'b1, last: 1'b0, size: REQ_SZ_LINE, typ: PKT_TYPE_FETCH, addr: bus.i_req_addr, data: 64'd0};
    slot_d = slot_q;
    slot_d.vld = slot_q.vld && !bus.cpu_req_ack_xx;
    slot_d = gnt_d ? d_pkt : gnt_i ? i_pkt : slot_d;
    low_d = (bus.cpu_resp_pkt_xx.vld && !empty && head.is_line && !bus.cpu_resp_pkt_xx.last) ? bus.cpu_resp_pkt_xx.data : low_q;
    err_d = err_q || (bus.cpu_resp_pkt_xx.vld && empty);
    resp_data = head.is_line ? {bus.cpu_resp_pkt_xx.data, low_q} : {64'd0, bus.cpu_resp_pkt_xx.data};
    i_rv_d = fin && head.src == MEM_SRC_I;
    d_rv_d = fin && head.src == MEM_SRC_D;
    i_rd_d = i_rv_d ? resp_data : i_rd_q;
    d_rd_d = d_rv_d ? resp_data : d_rd_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot_q <= '0;
      pref_i_q <= 1'b0;
      err_q <= 1'b0;
      low_q <= '0;
      i_rv_q <= 1'b0;
      d_rv_q <= 1'b0;
      i_rd_q <= '0;
      d_rd_q <= '0;
    end else begin
      slot_q <= slot_d;
      pref_i_q <= pref_i_d;
      err_q <= err_d;
      low_q <= low_d;
      i_rv_q <= i_rv_d;
      d_rv_q <= d_rv_d;
      i_rd_q <= i_rd_d;
      d_rd_q <= d_rd_d;
    end
  assign bus.i_req_ack = gnt_i;
  assign bus.d_req_ack = gnt_d;
  assign bus.cpu_req_pkt_xx = slot_q;
  assign bus.i_resp_vld = i_rv_q;
  assign bus.d_resp_vld = d_rv_q;
  assign bus.i_resp_data = i_rd_q;
  assign bus.d_resp_data = d_rd_q;
  assign bus.err_orphan = err_q;
endmodule

// File: tb/tb_alpha_mem_arb.sv
// tb_alpha_mem_arb: vector table for fetch/store/load flows plus hand sequences for arbitration, stalls, full FIFO and reset
module tb_alpha_mem_arb;
  import alpha_mem_arb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  alpha_mem_arb_if bus ();
  alpha_mem_arb #(.SRC_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic iv; logic [31:0] ia;
    logic dv; pkt_type_e dt; pkt_size_e ds; logic [31:0] da; logic [63:0] dw;
    logic ack; pkt_t rsp;
    logic eia; logic eda; pkt_t epkt; logic eirv; logic edrv;
    logic [127:0] eid; logic [127:0] edd; logic eerr;
  } vec_t;

  function automatic pkt_t mk(logic v, logic l, pkt_size_e s, pkt_type_e t, logic [31:0] a, logic [63:0] d);
    mk = '{vld: v, last: l, size: s, typ: t, addr: a, data: d};
  endfunction

  function automatic pkt_t beat(logic l, logic [63:0] d);
    beat = mk(1'b1, l, REQ_SZ_BYTE, PKT_TYPE_FETCH, 32'h0, d);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic iv, input logic [31:0] ia, input logic dv, input pkt_type_e dt,
                     input pkt_size_e ds, input logic [31:0] da, input logic [63:0] dw,
                     input logic ack, input pkt_t rsp);
    bus.i_req_vld = iv;
    bus.i_req_addr = ia;
    bus.d_req_vld = dv;
    bus.d_req_type = dt;
    bus.d_req_size = ds;
    bus.d_req_addr = da;
    bus.d_req_wdata = dw;
    bus.cpu_req_ack_xx = ack;
    bus.cpu_resp_pkt_xx = rsp;
  endtask

  task automatic idle(input logic ack);
    drv(1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, ack, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl [12];
  pkt_t z, p_i, p_i0, p_s, p_l, p_l0;
  logic [127:0] idat, ddat;

  initial begin
    z = '0;
    p_i = mk(1'b1, 1'b0, REQ_SZ_LINE, PKT_TYPE_FETCH, 32'h1004, 64'h0);
    p_i0 = mk(1'b0, 1'b0, REQ_SZ_LINE, PKT_TYPE_FETCH, 32'h1004, 64'h0);
    p_s = mk(1'b1, 1'b0, REQ_SZ_BYTE, PKT_TYPE_STORE, 32'h2003, 64'h55);
    p_l = mk(1'b1, 1'b0, REQ_SZ_DWORD, PKT_TYPE_LOAD, 32'h2000, 64'h0);
    p_l0 = mk(1'b0, 1'b0, REQ_SZ_DWORD, PKT_TYPE_LOAD, 32'h2000, 64'h0);
    idat = {64'hB, 64'hA};
    ddat = {64'h0, 64'h1122334455667788};
    tbl[0]  = '{1'b1, 32'h1004, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, z, 1'b1, 1'b0, z, 1'b0, 1'b0, 128'h0, 128'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b1, z, 1'b0, 1'b0, p_i, 1'b0, 1'b0, 128'h0, 128'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, beat(1'b0, 64'hA), 1'b0, 1'b0, p_i0, 1'b0, 1'b0, 128'h0, 128'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, beat(1'b1, 64'hB), 1'b0, 1'b0, p_i0, 1'b0, 1'b0, 128'h0, 128'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, z, 1'b0, 1'b0, p_i0, 1'b1, 1'b0, idat, 128'h0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, z, 1'b0, 1'b0, p_i0, 1'b0, 1'b0, idat, 128'h0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, PKT_TYPE_STORE, REQ_SZ_BYTE, 32'h2003, 64'h55, 1'b0, z, 1'b0, 1'b1, p_i0, 1'b0, 1'b0, idat, 128'h0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 1'b1, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h2000, 64'h0, 1'b1, z, 1'b0, 1'b1, p_s, 1'b0, 1'b0, idat, 128'h0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b1, beat(1'b1, 64'h0), 1'b0, 1'b0, p_l, 1'b0, 1'b0, idat, 128'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, beat(1'b1, 64'h1122334455667788), 1'b0, 1'b0, p_l0, 1'b0, 1'b1, idat, 128'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, z, 1'b0, 1'b0, p_l0, 1'b0, 1'b1, idat, ddat, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, z, 1'b0, 1'b0, p_l0, 1'b0, 1'b0, idat, ddat, 1'b0};

    // reset state with both clients requesting
    drv(1'b1, 32'h1000, 1'b1, PKT_TYPE_LOAD, REQ_SZ_WORD, 32'h2000, 64'h0, 1'b0, '0);
    #1;
    chk("rst_i_ack", bus.i_req_ack, 0);
    chk("rst_d_ack", bus.d_req_ack, 0);
    chk("rst_pkt", bus.cpu_req_pkt_xx, 0);
    chk("rst_resp_vld", {bus.i_resp_vld, bus.d_resp_vld}, 0);
    chk("rst_data", bus.i_resp_data | bus.d_resp_data, 0);
    chk("rst_err", bus.err_orphan, 0);
    do_reset();

    for (int k = 0; k < 12; k++) begin
      drv(tbl[k].iv, tbl[k].ia, tbl[k].dv, tbl[k].dt, tbl[k].ds, tbl[k].da, tbl[k].dw, tbl[k].ack, tbl[k].rsp);
      #1;
      chk($sformatf("v%0d_i_ack", k), bus.i_req_ack, tbl[k].eia);
      chk($sformatf("v%0d_d_ack", k), bus.d_req_ack, tbl[k].eda);
      chk($sformatf("v%0d_pkt", k), bus.cpu_req_pkt_xx, tbl[k].epkt);
      chk($sformatf("v%0d_i_rv", k), bus.i_resp_vld, tbl[k].eirv);
      chk($sformatf("v%0d_d_rv", k), bus.d_resp_vld, tbl[k].edrv);
      chk($sformatf("v%0d_i_data", k), bus.i_resp_data, tbl[k].eid);
      chk($sformatf("v%0d_d_data", k), bus.d_resp_data, tbl[k].edd);
      chk($sformatf("v%0d_err", k), bus.err_orphan, tbl[k].eerr);
      @(negedge clk);
    end

    // simultaneous requests from reset: D first, then I
    do_reset();
    drv(1'b1, 32'h3000, 1'b1, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h4000, 64'h0, 1'b1, '0);
    #1;
    chk("sim_c0_d_ack", bus.d_req_ack, 1);
    chk("sim_c0_i_ack", bus.i_req_ack, 0);
    @(negedge clk);
    drv(1'b1, 32'h3000, 1'b0, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h4000, 64'h0, 1'b1, '0);
    #1;
    chk("sim_c1_i_ack", bus.i_req_ack, 1);
    chk("sim_c1_d_ack", bus.d_req_ack, 0);
    chk("sim_c1_pkt", bus.cpu_req_pkt_xx, mk(1'b1, 1'b0, REQ_SZ_DWORD, PKT_TYPE_LOAD, 32'h4000, 64'h0));
    @(negedge clk);
    idle(1'b1);
    bus.cpu_resp_pkt_xx = beat(1'b1, 64'hD);
    #1;
    chk("sim_c2_pkt", bus.cpu_req_pkt_xx, mk(1'b1, 1'b0, REQ_SZ_LINE, PKT_TYPE_FETCH, 32'h3000, 64'h0));
    @(negedge clk);
    bus.cpu_resp_pkt_xx = beat(1'b0, 64'h1);
    #1;
    chk("sim_d_rv", {bus.i_resp_vld, bus.d_resp_vld}, 2'b01);
    chk("sim_d_data", bus.d_resp_data, {64'h0, 64'hD});
    @(negedge clk);
    bus.cpu_resp_pkt_xx = beat(1'b1, 64'h2);
    #1;
    chk("sim_mid_rv", {bus.i_resp_vld, bus.d_resp_vld}, 2'b00);
    @(negedge clk);
    idle(1'b1);
    #1;
    chk("sim_i_rv", {bus.i_resp_vld, bus.d_resp_vld}, 2'b10);
    chk("sim_i_data", bus.i_resp_data, {64'h2, 64'h1});
    @(negedge clk);

    // backpressure: slot holds while MIU withholds ack
    do_reset();
    drv(1'b0, 32'h0, 1'b1, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h5000, 64'h0, 1'b0, '0);
    #1;
    chk("bp_first_ack", bus.d_req_ack, 1);
    @(negedge clk);
    drv(1'b0, 32'h0, 1'b1, PKT_TYPE_STORE, REQ_SZ_WORD, 32'h6000, 64'h77, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_ack", k), bus.d_req_ack, 0);
      chk($sformatf("bp%0d_pkt", k), bus.cpu_req_pkt_xx, mk(1'b1, 1'b0, REQ_SZ_DWORD, PKT_TYPE_LOAD, 32'h5000, 64'h0));
      @(negedge clk);
    end

    // FIFO full: 4 outstanding blocks the 5th until a final beat pops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 32'h0, 1'b1, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h100 + 32'(8 * k), 64'h0, 1'b1, '0);
      #1;
      chk($sformatf("full_ack%0d", k), bus.d_req_ack, 1);
      @(negedge clk);
    end
    drv(1'b0, 32'h0, 1'b1, PKT_TYPE_LOAD, REQ_SZ_DWORD, 32'h120, 64'h0, 1'b1, '0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("full_block%0d", k), bus.d_req_ack | bus.i_req_ack, 0);
      @(negedge clk);
    end
    bus.cpu_resp_pkt_xx = beat(1'b1, 64'h99);
    #1;
    chk("full_pop_ack", bus.d_req_ack, 1);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("full_pop_rv", bus.d_resp_vld, 1);
    chk("full_pop_data", bus.d_resp_data, {64'h0, 64'h99});
    chk("full_new_pkt", bus.cpu_req_pkt_xx, mk(1'b1, 1'b0, REQ_SZ_DWORD, PKT_TYPE_LOAD, 32'h120, 64'h0));
    @(negedge clk);

    // orphan beat, then asynchronous reset mid-line
    do_reset();
    idle(1'b0);
    bus.cpu_resp_pkt_xx = beat(1'b1, 64'h5);
    #1;
    chk("orph_pre", bus.err_orphan, 0);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("orph_set", bus.err_orphan, 1);
    chk("orph_no_rv", {bus.i_resp_vld, bus.d_resp_vld}, 2'b00);
    @(negedge clk);
    #1;
    chk("orph_sticky", bus.err_orphan, 1);
    @(negedge clk);
    drv(1'b1, 32'h7000, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b1, '0);
    #1;
    chk("mid_i_ack", bus.i_req_ack, 1);
    @(negedge clk);
    drv(1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b1, beat(1'b0, 64'h31));
    @(negedge clk);
    drv(1'b1, 32'h8000, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, '0);
    #1;
    chk("mid_pre_ack", bus.i_req_ack, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_acks", {bus.i_req_ack, bus.d_req_ack}, 2'b00);
    chk("mid_rst_pkt", bus.cpu_req_pkt_xx, 0);
    chk("mid_rst_rv", {bus.i_resp_vld, bus.d_resp_vld}, 2'b00);
    chk("mid_rst_data", bus.i_resp_data | bus.d_resp_data, 0);
    chk("mid_rst_err", bus.err_orphan, 0);
    @(negedge clk);
    reset = 1'b1;
    drv(1'b0, 32'h0, 1'b0, PKT_TYPE_FETCH, REQ_SZ_BYTE, 32'h0, 64'h0, 1'b0, beat(1'b1, 64'h32));
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("late_beat_err", bus.err_orphan, 1);
    chk("late_beat_rv", bus.i_resp_vld, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alpha_mem_arb.md
# alpha_mem_arb

Two-client request arbiter and response router placed directly upstream of the memory interface unit (MIU). It accepts memory requests from the instruction-fetch client (port I) and the load/store client (port D), serialises them into single MIU request packets, and routes every MIU response packet back to its originating client in order. For line requests, the two 64-bit response beats are assembled into one 128-bit response.

## Interface
Parameters:
- `SRC_DEPTH`, default 4: maximum number of outstanding MIU transactions tracked (power of 2, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req_vld`  in  1  port I request valid; held until `i_req_ack`.
- `i_req_addr`  in  32  port I address. Port I type is always FETCH and its size is always `REQ_SZ_LINE`.
- `i_req_ack`  out  1  port I request accepted this cycle.
- `i_resp_vld`  out  1  port I response valid, single-cycle pulse.
- `i_resp_data`  out  128  port I line data, {beat at addr+8, beat at base}.
- `d_req_vld`  in  1  port D request valid; held until `d_req_ack`.
- `d_req_addr`  in  32  port D address.
- `d_req_type`  in  `PKT_TYPE` width  port D type: LOAD or STORE.
- `d_req_size`  in  `PKT_SIZE` width  port D size, including `REQ_SZ_LINE`.
- `d_req_wdata`  in  64  port D store data, unshifted.
- `d_req_ack`  out  1  port D request accepted this cycle.
- `d_resp_vld`  out  1  port D response valid pulse. Stores also receive a response.
- `d_resp_data`  out  128  port D data. For non-line requests only [63:0] is valid and [127:64] is 0.
- `cpu_req_pkt_xx`  out  `PKT_BITS`  request packet to the MIU.
- `cpu_req_ack_xx`  in  1  MIU has consumed the request packet.
- `cpu_resp_pkt_xx`  in  `PKT_BITS`  response packet from the MIU; a beat is present when its `PKT_VLD` bit is set.
- `err_orphan`  out  1  sticky flag: a response arrived while no transaction was outstanding.

## Operation
- **Request slot.** A single registered packet drives `cpu_req_pkt_xx` directly. Its VLD bit is cleared on a cycle where `cpu_req_ack_xx`=1, unless a new request is loaded in that same cycle.
- **Accept condition.** A request is accepted when both hold:
  - the slot is empty, or is being acked this cycle;
  - the source FIFO is not full, counting any entry being pushed or popped this cycle.
- **Arbitration.** Round-robin on a 1-bit pointer that names the preferred port. When both ports request, the preferred port wins. After every grant the pointer moves to the other port. Exactly one of `i_req_ack`/`d_req_ack` can be asserted per cycle, and each is combinational from the request and accept conditions.
- **Packet build.** Set VLD=1 and LAST=0. Fill ADDR, TYPE, SIZE and DATA from the granted port. Port I uses TYPE=FETCH, SIZE=`REQ_SZ_LINE`, DATA=0.
- **Source FIFO.** `SRC_DEPTH` entries, each holding {src, is_line}. Push on grant; pop on the final response beat. Responses return strictly in order.
- **Response handling**, for a response beat with the FIFO non-empty:
  - head is_line=0: that beat is final; data goes to [63:0].
  - head is_line=1 and LAST=0: store the beat in a 64-bit low buffer; no client response.
  - head is_line=1 and LAST=1: final beat; output {beat, low buffer}.
- **Orphan beats.** A response beat that arrives with the FIFO empty is dropped and sets `err_orphan`. Only reset clears `err_orphan`.
- **Response outputs.** Registered: `x_resp_vld` pulses for exactly one cycle for the matching source. `x_resp_data` holds its value until the next response to that port.

## Timing
- **Reset values.** All outputs reset to 0: `cpu_req_pkt_xx`, both acks, both resp_vld, both resp_data, `err_orphan`. Reset also clears the pointer (preferred port = D), the FIFO pointers and count, and the low buffer.
- **Reset mid-operation.** Asynchronous assertion clears everything immediately. In-flight MIU beats that arrive after deassertion become orphans.
- **Request latency.** A request acked in cycle N is visible on `cpu_req_pkt_xx` in N+1.
- **Slot hold.** The slot stays stable while `cpu_req_ack_xx`=0.
- **Back-to-back requests.** Sustained throughput is one request per cycle while the MIU acks every cycle.
- **Response latency.** A final beat in cycle M produces `x_resp_vld` in M+1.
- **FIFO full.** With `SRC_DEPTH` transactions outstanding, both acks stay 0. If a final beat pops in cycle M, a new grant is allowed in the same cycle M.
- **Wrap-around.** FIFO pointers are log2(`SRC_DEPTH`) bits and wrap naturally; count is log2(`SRC_DEPTH`)+1 bits.

## Structure
- The packet field macros, `PKT_TYPE_*` and `REQ_SZ_LINE` stay in `defines.vh`.
- Add `MEM_SRC_I`=1'b0 and `MEM_SRC_D`=1'b1 to `defines.vh`.
- One sub-module, `alpha_src_fifo`: synchronous-write, parameterised-depth, 2-bit-wide FIFO with full/empty outputs and simultaneous push/pop support.

## Test plan
- **Single I line fetch.** `i_req_addr`=0x1004; MIU returns LAST=0 data 0xA then LAST=1 data 0xB. Required: packet ADDR=0x1004, SIZE=LINE; `i_resp_vld` one cycle after the second beat with data {0xB,0xA}; `d_resp_vld` stays 0.
- **Simultaneous requests.** Both ports request from reset. Required: D acked in cycle 0, I acked in cycle 1; responses are routed D first, then I.
- **D store then load.** Store 0x55 (size byte) to 0x2003, then load from 0x2000. Required: two `d_resp_vld` pulses in order; the store response has data ignored; the load returns the MIU data in [63:0] with [127:64]=0.
- **Backpressure.** Hold `cpu_req_ack_xx`=0 for 5 cycles with D requesting. Required: slot packet is unchanged; `d_req_ack` asserts only once, at the initial grant into the empty slot.
- **FIFO full.** With `SRC_DEPTH`=4, issue 4 requests and no responses. Required: the 5th is not acked; returning one response allows the 5th ack in that same cycle.
- **Orphan and reset.** Inject a response with the FIFO empty → `err_orphan`=1. Assert `reset` mid-line-transfer → all outputs read 0 in the same cycle.
